stopwatch_lap_core: RTL and testbench

Stopwatch core with lap-freeze. It counts seconds and centiseconds (00.00 to 59.99) in packed BCD. Upstream, it is driven by one-cycle button pulses from button_cntr instances. Downstream, it feeds the 16-bit value input of fnd_4digit_cntr directly, in the same position as the minute/second BCD bus in the watch design.

---
 rtl/stopwatch_lap_core.sv | 158 +++++++++++++++
 tb/tb_stopwatch_lap_core.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap_core.sv
// stopwatch_lap_core
// Stopwatch core with lap-freeze. Counts seconds and centiseconds from 00.00
// to 59.99 in packed BCD. The lap feature freezes the displayed value while
// the count keeps running underneath.
//
// Ports:
//   clk        system clock
//   reset_p    asynchronous active-high reset
//   start_pe   one-cycle pulse, start/stop toggle
//   lap_pe     one-cycle pulse, lap freeze/release
//   clear_pe   one-cycle pulse, zero the count (only while paused)
//   value      {sec10,sec1,csec10,csec1} BCD for the 4-digit display
//   running    high in RUN or LAP
//   lap_active high while the display is frozen (LAP)
//   wrap       one-cycle pulse when the count rolls 59.99 -> 00.00
module stopwatch_lap_core #(
  parameter int TICK_DIV   = 1_000_000,
  parameter int PRESCALE_W = 20
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        start_pe,
  input  logic        lap_pe,
  input  logic        clear_pe,
  output logic [15:0] value,
  output logic        running,
  output logic        lap_active,
  output logic        wrap
);

  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

  localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(TICK_DIV - 1);

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [15:0]           count_q, count_d;
  logic [15:0]           lap_q, lap_d;
  logic                  wrap_q, wrap_d;

  logic                  countEn;
  logic                  tick;
  logic                  clearHit;
  logic                  lapCapture;
  logic [15:0]           countInc;

  // The count only advances in RUN and LAP. The enable is taken from the
  // current state, so a tick landing on the same edge as a stop still counts.
  always_comb begin
    countEn = (state_q == RUN) || (state_q == LAP);
    tick    = countEn && (presc_q == PRESC_LAST);
  end

  // Next-state logic. Priority is start over lap over clear; lower-priority
  // pulses arriving together with a higher one are simply dropped.
  always_comb begin
    state_d    = state_q;
    clearHit   = 1'b0;
    lapCapture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_pe) state_d = RUN;
      end
      RUN: begin
        if (start_pe) begin
          state_d = PAUSE;
        end else if (lap_pe) begin
          state_d    = LAP;
          lapCapture = 1'b1;
        end
      end
      LAP: begin
        if (start_pe)    state_d = PAUSE;
        else if (lap_pe) state_d = RUN;
      end
      PAUSE: begin
        if (start_pe) begin
          state_d = RUN;
        end else if (clear_pe) begin
          state_d  = IDLE;
          clearHit = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // BCD increment with carry ripple through the four digits; sec10 rolls at 5
  // so the whole count wraps from 59.99 to 00.00.
  always_comb begin
    countInc = count_q;
    if (count_q[3:0] == 4'd9) begin
      countInc[3:0] = 4'd0;
      if (count_q[7:4] == 4'd9) begin
        countInc[7:4] = 4'd0;
        if (count_q[11:8] == 4'd9) begin
          countInc[11:8] = 4'd0;
          if (count_q[15:12] == 4'd5) countInc[15:12] = 4'd0;
          else                        countInc[15:12] = count_q[15:12] + 4'd1;
        end else begin
          countInc[11:8] = count_q[11:8] + 4'd1;
        end
      end else begin
        countInc[7:4] = count_q[7:4] + 4'd1;
      end
    end else begin
      countInc[3:0] = count_q[3:0] + 4'd1;
    end
  end

  // Datapath next values. The prescaler holds while stopped so a pause does
  // not lose the partial tick; a clear from PAUSE zeroes everything. The lap
  // register grabs the count as it stood before any same-edge tick.
  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    lap_d   = lap_q;
    wrap_d  = 1'b0;
    if (clearHit) begin
      presc_d = '0;
      count_d = '0;
      lap_d   = '0;
    end else begin
      if (countEn) presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        count_d = countInc;
        wrap_d  = (count_q == 16'h5999);
      end
      if (lapCapture) lap_d = count_q;
    end
  end

  // All state registers share the asynchronous reset.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= IDLE;
      presc_q <= '0;
      count_q <= '0;
      lap_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      count_q <= count_d;
      lap_q   <= lap_d;
      wrap_q  <= wrap_d;
    end
  end

  // Display shows the frozen lap value in LAP, otherwise the live count.
  always_comb begin
    value      = (state_q == LAP) ? lap_q : count_q;
    running    = (state_q == RUN) || (state_q == LAP);
    lap_active = (state_q == LAP);
    wrap       = wrap_q;
  end

endmodule

// File: tb/tb_stopwatch_lap_core.sv
module tb_stopwatch_lap_core;

  logic        clk;
  logic        reset_p;
  logic        start_pe;
  logic        lap_pe;
  logic        clear_pe;
  logic [15:0] value;
  logic        running;
  logic        lap_active;
  logic        wrap;

  int vectorCount = 0;
  int missCount   = 0;
  int wrapSeen    = 0;

  stopwatch_lap_core #(
    .TICK_DIV  (4),
    .PRESCALE_W(20)
  ) dut (
    .clk       (clk),
    .reset_p   (reset_p),
    .start_pe  (start_pe),
    .lap_pe    (lap_pe),
    .clear_pe  (clear_pe),
    .value     (value),
    .running   (running),
    .lap_active(lap_active),
    .wrap      (wrap)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and log any miss
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Advance n clock edges, sampling 1 ns after each edge and tallying wrap
  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (wrap) wrapSeen++;
    end
  endtask

  // Drive a set of one-cycle pulses across exactly one clock edge
  task automatic applyStimulus(input logic s, input logic l, input logic c);
    start_pe = s;
    lap_pe   = l;
    clear_pe = c;
    stepCycles(1);
    start_pe = 1'b0;
    lap_pe   = 1'b0;
    clear_pe = 1'b0;
  endtask

  initial begin
    reset_p  = 1'b1;
    start_pe = 1'b0;
    lap_pe   = 1'b0;
    clear_pe = 1'b0;
    #22;
    checkOutput("reset value", value, 16'h0000);
    checkOutput("reset running", {15'd0, running}, 16'd0);
    checkOutput("reset lap_active", {15'd0, lap_active}, 16'd0);
    checkOutput("reset wrap", {15'd0, wrap}, 16'd0);
    #5;
    reset_p = 1'b0;

    // Idle: nothing moves for 100 cycles
    stepCycles(100);
    checkOutput("idle value", value, 16'h0000);
    checkOutput("idle running", {15'd0, running}, 16'd0);
    checkOutput("idle wrap count", 16'(wrapSeen), 16'd0);

    // Start and count 10 ticks
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycles(40);
    checkOutput("run 10 ticks", value, 16'h0010);
    checkOutput("run running", {15'd0, running}, 16'd1);
    checkOutput("run lap_active", {15'd0, lap_active}, 16'd0);

    // Pause with prescaler landing on 2, then resume
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycles(10);
    checkOutput("paused value", value, 16'h0010);
    checkOutput("paused running", {15'd0, running}, 16'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycles(1);
    checkOutput("resume +1 no tick", value, 16'h0010);
    stepCycles(1);
    checkOutput("resume +2 tick", value, 16'h0011);

    // Lap freeze at 00.12, count continues to 00.17 underneath
    stepCycles(4);
    checkOutput("pre-lap value", value, 16'h0012);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycles(20);
    checkOutput("lap frozen", value, 16'h0012);
    checkOutput("lap lap_active", {15'd0, lap_active}, 16'd1);
    checkOutput("lap running", {15'd0, running}, 16'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("lap release live", value, 16'h0017);
    checkOutput("lap release flag", {15'd0, lap_active}, 16'd0);

    // Clear in RUN is ignored
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clear in run value", value, 16'h0017);
    checkOutput("clear in run running", {15'd0, running}, 16'd1);

    // Stop on the tick edge: tick still applied
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("stop with tick", value, 16'h0018);
    checkOutput("stop running", {15'd0, running}, 16'd0);

    // start+clear in PAUSE: start wins, count kept
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("start+clear value", value, 16'h0018);
    checkOutput("start+clear running", {15'd0, running}, 16'd1);

    // Pause again then clear alone -> IDLE and zero
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clear in pause value", value, 16'h0000);
    checkOutput("clear in pause running", {15'd0, running}, 16'd0);

    // Lap pulse in IDLE is ignored
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("lap in idle", {15'd0, lap_active}, 16'd0);
    checkOutput("lap in idle running", {15'd0, running}, 16'd0);

    // Full wrap: 6000 ticks from 00.00
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycles(23999);
    checkOutput("before wrap", value, 16'h5999);
    checkOutput("before wrap pulse", {15'd0, wrap}, 16'd0);
    stepCycles(1);
    checkOutput("wrap value", value, 16'h0000);
    checkOutput("wrap pulse", {15'd0, wrap}, 16'd1);
    stepCycles(1);
    checkOutput("wrap pulse width", {15'd0, wrap}, 16'd0);
    stepCycles(3);
    checkOutput("after wrap counting", value, 16'h0001);
    checkOutput("total wrap pulses", 16'(wrapSeen), 16'd1);

    // Asynchronous reset mid-RUN
    stepCycles(10);
    #2;
    reset_p = 1'b1;
    #1;
    checkOutput("async reset value", value, 16'h0000);
    checkOutput("async reset running", {15'd0, running}, 16'd0);
    #3;
    reset_p = 1'b0;
    stepCycles(8);
    checkOutput("post reset idle", value, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
